tnoc_local_port_mux: RTL and testbench
======================================

TNOC_LOCAL_PORT_MUX -- requirements
Module: tnoc_local_port_mux

Interface
REQ-001 Parameter PACKET_CONFIG, default TNOC_DEFAULT_PACKET_CONFIG, sets the flit format carried on all ports.
REQ-002 Parameter INPUTS, default 2, sets the number of source streams merged, range 2..8.
REQ-003 Parameter DEPTH, default 2, sets the output buffer entries, range 2..4.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: i_clk and i_rst.
REQ-005 i_clk  input  1  clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  INPUTS  per-source flit valid.
REQ-008 o_ready  output  INPUTS  per-source flit accept.
REQ-009 i_flit  input  INPUTS x tnoc_flit  per-source flit with head, tail and data fields.
REQ-010 o_valid  output  1  flit valid toward the router local receiver port.
REQ-011 i_ready  input  1  router local port accept.
REQ-012 o_flit  output  tnoc_flit  merged flit stream.

Function
REQ-013 Transfer on any port SHALL occur only when valid and ready are both high in the same cycle.
REQ-014 Output buffer: FIFO of DEPTH flits; o_valid = (count != 0); o_flit = oldest entry.
REQ-015 Space SHALL be (count < DEPTH), computed from registers only, so o_ready has no combinational path from i_ready.
REQ-016 Arbiter states: IDLE (no packet owns the output) and LOCKED (grant_q owns the output until it sends its tail).
REQ-017 In IDLE with space, grant SHALL go to the first source with i_valid high, searching from rr_ptr upward and wrapping at INPUTS-1 to 0.
REQ-018 In LOCKED, grant SHALL equal grant_q regardless of other valids.
REQ-019 o_ready[g] SHALL equal space for the granted source only; every other o_ready bit is 0.
REQ-020 An accepted flit with tail=0 SHALL move IDLE->LOCKED with grant_q = g.
REQ-021 An accepted flit with tail=1 SHALL move the arbiter to IDLE and set rr_ptr = (g+1) mod INPUTS.
REQ-022 A head+tail single-flit packet SHALL leave the arbiter in IDLE and advance rr_ptr.
REQ-023 A LOCKED source holding i_valid low SHALL keep the lock with no timeout; other sources wait.
REQ-024 Latency SHALL be one cycle from input acceptance to o_valid/o_flit; when neither stalls, throughput SHALL be one flit per cycle.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; a pop at count=1 with push SHALL present the new flit the next cycle.
REQ-026 At count=DEPTH, all o_ready bits SHALL be 0, and arbitration state SHALL hold.
REQ-027 Flits SHALL pass unmodified; packet order per source and flit order within a packet SHALL be preserved.
REQ-028 Flits of different packets SHALL never interleave on o_flit.

Reset
REQ-029 While i_rst is high: o_valid=0, o_ready=0, count=0, state=IDLE, rr_ptr=0, grant_q=0.
REQ-030 Reset mid-packet SHALL discard buffered flits and the lock; the first flit accepted after reset starts arbitration afresh.

Structure
REQ-031 tnoc_flit typedef, flit field helpers and the tnoc_packet_config type SHALL live in tnoc_pkg; rr_ptr/grant widths SHALL derive locally from $clog2(INPUTS).
REQ-032 Output buffer SHALL be a sub-module tnoc_flit_fifo (DEPTH, synchronous active-high reset); arbiter and lock FSM SHALL stay in tnoc_local_port_mux.

Verification
REQ-033 INPUTS=2: src0 sends 3-flit packet, src1 sends 2-flit packet, same first cycle, i_ready=1 -> output is src0 flits 0..2, then src1 flits 0..1, no gap; rr_ptr=0 after.
REQ-034 Both sources continuously send single-flit packets -> output alternates src0, src1, src0, ...
REQ-035 src0 mid-packet drops i_valid for 4 cycles while src1 is valid -> no src1 flit appears until src0's tail is output.
REQ-036 i_ready=0 for 5 cycles with src0 streaming, DEPTH=2 -> exactly 2 flits accepted, o_ready[0]=0 from cycle 2 on; on release, data in order with no loss or duplication.
REQ-037 Assert i_rst for one cycle after 2nd flit of a 4-flit src1 packet -> next cycle o_valid=0, count=0; src0 single-flit packet is then granted first (rr_ptr=0).
REQ-038 Random valid/ready, INPUTS=4, 10k cycles -> scoreboard shows no packet interleaving, per-source order preserved, no o_ready asserted on a non-granted source.

Source files
------------

// File: rtl/tnoc_pkg.sv
// Shared flit format, packet configuration type and flit field helpers for tnoc blocks.
package tnoc_pkg;

  localparam int unsigned TnocDataWidth = 32;

  // Static description of the flit format a port carries.
  typedef struct packed {
    int unsigned data_width;
  } tnoc_packet_config;

  localparam tnoc_packet_config TNOC_DEFAULT_PACKET_CONFIG = '{data_width: TnocDataWidth};

  typedef struct packed {
    logic                     head;
    logic                     tail;
    logic [TnocDataWidth-1:0] data;
  } tnoc_flit;

  function automatic logic tnoc_flit_is_head(tnoc_flit flit);
    return flit.head;
  endfunction

  function automatic logic tnoc_flit_is_tail(tnoc_flit flit);
    return flit.tail;
  endfunction

  function automatic tnoc_flit tnoc_make_flit(logic head, logic tail,
                                              logic [TnocDataWidth-1:0] data);
    tnoc_flit flit;
    flit.head = head;
    flit.tail = tail;
    flit.data = data;
    return flit;
  endfunction

endpackage

// File: rtl/tnoc_local_port_mux_if.sv
// Handshake bundle between several flit sources, the local port mux and the router port.
interface tnoc_local_port_mux_if #(
  parameter int unsigned INPUTS = 2
);
  import tnoc_pkg::*;

  // Source side: one valid/ready/flit lane per source.
  logic     [INPUTS-1:0] i_valid;
  logic     [INPUTS-1:0] o_ready;
  tnoc_flit [INPUTS-1:0] i_flit;

  // Router side: single merged stream.
  logic                  o_valid;
  logic                  i_ready;
  tnoc_flit              o_flit;

  // The mux itself.
  modport slave (
    input  i_valid,
    input  i_flit,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_flit
  );

  // Sources and router port model driving the mux.
  modport master (
    output i_valid,
    output i_flit,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_flit
  );

endinterface

// File: rtl/tnoc_flit_fifo.sv
// Small flit FIFO with registered occupancy; full depends only on state.
module tnoc_flit_fifo
  import tnoc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  tnoc_flit i_flit,
  output logic     o_full,
  input  logic     i_pop,
  output logic     o_valid,
  output tnoc_flit o_flit
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  tnoc_flit        mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push;
  logic            pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (count_q == CntW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign o_flit  = mem_q[rd_ptr_q];
  assign push    = i_push && !o_full;
  assign pop     = i_pop && o_valid;

  // Next pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_flit;
    end
  end

endmodule

// File: rtl/tnoc_local_port_mux.sv
// Merges INPUTS flit streams into one router local port with packet-level round-robin
// arbitration; a packet holds the output from its first accepted flit until its tail.
module tnoc_local_port_mux
  import tnoc_pkg::*;
#(
  parameter tnoc_packet_config PACKET_CONFIG = TNOC_DEFAULT_PACKET_CONFIG,
  parameter int unsigned       INPUTS        = 2,
  parameter int unsigned       DEPTH         = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  tnoc_local_port_mux_if.slave port_if
);

  localparam int unsigned PtrW = $clog2(INPUTS);

  if (INPUTS < 2 || INPUTS > 8) begin : g_bad_inputs
    $error("tnoc_local_port_mux: INPUTS must be 2..8");
  end
  if (DEPTH < 2 || DEPTH > 4) begin : g_bad_depth
    $error("tnoc_local_port_mux: DEPTH must be 2..4");
  end
  if (PACKET_CONFIG.data_width != TnocDataWidth) begin : g_bad_config
    $error("tnoc_local_port_mux: PACKET_CONFIG does not match tnoc_flit");
  end

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  arb_state_e      state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] grant_q, grant_d;
  logic [PtrW-1:0] grant;
  logic [PtrW-1:0] cand;
  logic            grant_valid;
  logic            space;
  logic            fifo_full;
  logic            fifo_valid;
  logic            accept;
  logic            pop;
  tnoc_flit        accept_flit;
  tnoc_flit        fifo_flit;
  logic [INPUTS-1:0] ready;

  function automatic logic [PtrW-1:0] wrap_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(INPUTS - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Space comes from registered occupancy only, so o_ready never sees i_ready.
  assign space = !fifo_full;

  // Grant selection: locked owner, else first valid source at or after rr_ptr.
  always_comb begin
    grant       = grant_q;
    grant_valid = 1'b0;
    cand        = '0;
    if (state_q == StLocked) begin
      grant_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < INPUTS; k++) begin
        cand = PtrW'((32'(rr_ptr_q) + k) % INPUTS);
        if (!grant_valid && port_if.i_valid[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Only the granted source may see ready, and only while the buffer has room.
  always_comb begin
    ready = '0;
    if (grant_valid && space && !i_rst) begin
      ready[grant] = 1'b1;
    end
  end

  assign accept      = port_if.i_valid[grant] && ready[grant];
  assign accept_flit = port_if.i_flit[grant];
  assign pop         = fifo_valid && port_if.i_ready && !i_rst;

  assign port_if.o_ready = ready;
  assign port_if.o_valid = fifo_valid && !i_rst;
  assign port_if.o_flit  = fifo_flit;

  // Lock FSM next state: a non-tail flit locks, a tail releases and advances rr_ptr.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (tnoc_flit_is_tail(accept_flit)) begin
        state_d  = StIdle;
        rr_ptr_d = wrap_inc(grant);
      end else begin
        state_d = StLocked;
        grant_d = grant;
      end
    end
  end

  // Arbiter state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  tnoc_flit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_flit  (accept_flit),
    .o_full  (fifo_full),
    .i_pop   (pop),
    .o_valid (fifo_valid),
    .o_flit  (fifo_flit)
  );

endmodule

// File: tb/tb_tnoc_local_port_mux.sv
// Bench for tnoc_local_port_mux: queue-based reference model checked every cycle,
// an output-stream packet scoreboard, and directed scenarios with literal expectations.
module tb_tnoc_local_port_mux;
  import tnoc_pkg::*;

  localparam int N = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tnoc_local_port_mux_if #(.INPUTS(N)) bus ();

  tnoc_local_port_mux #(
    .PACKET_CONFIG (TNOC_DEFAULT_PACKET_CONFIG),
    .INPUTS        (N),
    .DEPTH         (D)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .port_if (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Source generators.
  int pend [N][$];
  bit active [N];
  int len [N];
  int idx [N];
  int seq [N];
  bit hold [N];
  int vprob = 100;
  int rprob = 100;
  bit force_rdy_lo = 1'b0;
  bit acc [N];
  int acc_cnt [N];

  // Reference model: output buffer contents, packet owner, next round-robin start.
  tnoc_flit mq [$];
  int m_owner = -1;
  int m_ptr = 0;

  // Observed output stream.
  logic [31:0] out_data [$];
  int out_cyc [$];
  int last_seq [N];
  int last_idx [N];
  int cur_src = 0;
  bit out_in_pkt = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] dword(input int s, input int sq, input int ix);
    return {4'(s), 12'(sq), 16'(ix)};
  endfunction

  function automatic tnoc_flit mk(input int s);
    return tnoc_make_flit(idx[s] == 0, idx[s] == len[s] - 1, dword(s, seq[s], idx[s]));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // One cycle of stimulus, driven just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (acc[s]) begin
        idx[s]++;
        if (idx[s] == len[s]) begin
          active[s] = 1'b0;
          seq[s]++;
        end
      end
      if (!active[s] && pend[s].size() > 0) begin
        len[s]    = pend[s].pop_front();
        idx[s]    = 0;
        active[s] = 1'b1;
      end
      bus.i_valid[s] = active[s] && !hold[s] && ($urandom_range(99) < vprob);
      bus.i_flit[s]  = mk(s);
    end
    bus.i_ready = !force_rdy_lo && ($urandom_range(99) < rprob);
  endtask

  task automatic abort_all();
    for (int s = 0; s < N; s++) begin
      if (active[s]) begin
        active[s] = 1'b0;
        seq[s]++;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    abort_all();
    for (int s = 0; s < N; s++) begin
      pend[s].delete();
      hold[s] = 1'b0;
    end
    force_rdy_lo = 1'b0;
    vprob = 100;
    rprob = 100;
    step();
    step();
    rst = 1'b0;
    out_data.delete();
    out_cyc.delete();
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (out_data.size() < n && b > 0) begin
      step();
      b--;
    end
    check({name, "_complete"}, 64'(out_data.size() >= n), 64'd1);
  endtask

  task automatic log_out(input tnoc_flit f);
    int src;
    int sq;
    int ix;
    src = int'(f.data[31:28]);
    sq  = int'(f.data[27:16]);
    ix  = int'(f.data[15:0]);
    if (out_in_pkt) begin
      check("no_interleave_src", 64'(src), 64'(cur_src));
      check("intra_pkt_order", {sq[11:0], ix[15:0]},
            {12'(last_seq[cur_src]), 16'(last_idx[cur_src] + 1)});
    end else begin
      check("pkt_start_idx", 64'(ix), 64'd0);
      check("pkt_seq_order", 64'(sq > last_seq[src]), 64'd1);
    end
    if (src < N) begin
      last_seq[src] = sq;
      last_idx[src] = ix;
    end
    cur_src    = src;
    out_in_pkt = !f.tail;
    out_data.push_back(f.data);
    out_cyc.push_back(cyc);
  endtask

  // Compare DUT against the model mid-cycle, then advance the model past the next edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    int s2;
    bit exp_v;
    bit space;
    bit push;
    bit pop;
    if (rst) begin
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_o_ready", 64'(bus.o_ready), 64'd0);
      mq.delete();
      m_owner    = -1;
      m_ptr      = 0;
      out_in_pkt = 1'b0;
      for (int s = 0; s < N; s++) acc[s] = 1'b0;
    end else begin
      exp_v = (mq.size() != 0);
      space = (mq.size() < D);
      g = m_owner;
      if (g < 0) begin
        for (int k = 0; k < N; k++) begin
          s2 = (m_ptr + k) % N;
          if (g < 0 && bus.i_valid[s2]) g = s2;
        end
      end
      exp_rdy = '0;
      if (g >= 0 && space) exp_rdy[g] = 1'b1;
      check("o_ready", 64'(bus.o_ready), 64'(exp_rdy));
      check("o_valid", 64'(bus.o_valid), 64'(exp_v));
      if (exp_v) check("o_flit", 64'(bus.o_flit), 64'(mq[0]));
      for (int s = 0; s < N; s++) begin
        acc[s] = bus.i_valid[s] && bus.o_ready[s];
        if (acc[s]) acc_cnt[s]++;
      end
      if (bus.o_valid && bus.i_ready) log_out(bus.o_flit);
      pop  = exp_v && bus.i_ready;
      push = (g >= 0) && space && bus.i_valid[g];
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(bus.i_flit[g]);
        if (bus.i_flit[g].tail) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end else begin
          m_owner = g;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int b;
    int b0;
    int b1;
    logic [31:0] w;
    logic [31:0] exp_a [5];
    bus.i_valid = '0;
    bus.i_flit  = '0;
    bus.i_ready = 1'b0;
    for (int s = 0; s < N; s++) begin
      last_seq[s] = -1;
      last_idx[s] = 0;
      acc_cnt[s]  = 0;
    end

    // Reset state.
    repeat (3) step();
    @(negedge clk);
    #1;
    check("reset_o_valid", 64'(bus.o_valid), 64'd0);
    check("reset_o_ready", 64'(bus.o_ready), 64'd0);

    // src0 3-flit and src1 2-flit packets start together.
    reset_dut();
    pend[0].push_back(3);
    pend[1].push_back(2);
    wait_out(5, 40, "two_pkts");
    exp_a[0] = 32'h0000_0000;
    exp_a[1] = 32'h0000_0001;
    exp_a[2] = 32'h0000_0002;
    exp_a[3] = 32'h1000_0000;
    exp_a[4] = 32'h1000_0001;
    for (int k = 0; k < 5 && k < out_data.size(); k++) begin
      check("two_pkts_data", 64'(out_data[k]), 64'(exp_a[k]));
      check("two_pkts_no_gap", 64'(out_cyc[k] - out_cyc[0]), 64'(k));
    end

    // Single-flit packets from two sources alternate.
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      pend[0].push_back(1);
      pend[1].push_back(1);
    end
    wait_out(12, 60, "alternate");
    for (int k = 0; k < 12 && k < out_data.size(); k++) begin
      w = out_data[k];
      check("alternate_src", 64'(w[31:28]), 64'(k % 2));
    end

    // Locked source idles mid-packet; the other source must wait for its tail.
    reset_dut();
    b0 = seq[0];
    b1 = seq[1];
    pend[0].push_back(3);
    pend[1].push_back(1);
    a0 = acc_cnt[0];
    b  = 20;
    while (acc_cnt[0] == a0 && b > 0) begin
      step();
      b--;
    end
    check("lock_first_accept", 64'(acc_cnt[0] > a0), 64'd1);
    hold[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      #1;
      check("lock_other_ready", 64'(bus.o_ready[1]), 64'd0);
    end
    hold[0] = 1'b0;
    wait_out(4, 40, "lock");
    if (out_data.size() >= 4) begin
      check("lock_data0", 64'(out_data[0]), 64'(dword(0, b0, 0)));
      check("lock_data1", 64'(out_data[1]), 64'(dword(0, b0, 1)));
      check("lock_data2", 64'(out_data[2]), 64'(dword(0, b0, 2)));
      check("lock_data3", 64'(out_data[3]), 64'(dword(1, b1, 0)));
    end

    // Router stalls for 5 cycles while src0 streams: only DEPTH flits get in.
    reset_dut();
    b0 = seq[0];
    pend[0].push_back(6);
    a0 = acc_cnt[0];
    force_rdy_lo = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      #1;
      if (k >= 2) check("stall_ready0", 64'(bus.o_ready[0]), 64'd0);
    end
    check("stall_accepts", 64'(acc_cnt[0] - a0), 64'd2);
    force_rdy_lo = 1'b0;
    wait_out(6, 60, "stall");
    for (int k = 0; k < 6 && k < out_data.size(); k++) begin
      check("stall_data", 64'(out_data[k]), 64'(dword(0, b0, k)));
    end

    // One-cycle reset after the 2nd flit of a 4-flit src1 packet.
    reset_dut();
    pend[1].push_back(4);
    a0 = acc_cnt[1];
    b  = 30;
    while (acc_cnt[1] < a0 + 2 && b > 0) begin
      step();
      b--;
    end
    check("midrst_two_accepted", 64'(acc_cnt[1] - a0), 64'd2);
    rst = 1'b1;
    abort_all();
    out_data.delete();
    out_cyc.delete();
    pend[0].push_back(1);
    pend[1].push_back(1);
    step();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_o_valid", 64'(bus.o_valid), 64'd0);
    wait_out(2, 20, "midrst");
    if (out_data.size() >= 2) begin
      w = out_data[0];
      check("midrst_first_src", 64'(w[31:28]), 64'd0);
      w = out_data[1];
      check("midrst_second_src", 64'(w[31:28]), 64'd1);
    end

    // Random valid/ready traffic on all four sources.
    reset_dut();
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < 400; k++) pend[s].push_back(int'($urandom_range(1, 5)));
    end
    vprob = 60;
    rprob = 65;
    repeat (10000) step();
    check("random_progress", 64'(out_data.size() > 1000), 64'd1);

    vprob = 0;
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
